// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns the HI/LO registers. Radix-2 shift-add multiply and
// restoring divide both run on operand magnitudes; the sign is applied in a single fix-up cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]   a_orig, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, shifted, rem_next;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remd;

  always_comb begin
    sa    = ~op[0] & a[WIDTH-1];
    sb    = ~op[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    // Multiply: upper half accumulates, the multiplier drains out of the low half LSB first.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    // Divide: dividend bits leave acc[WIDTH-1] MSB first while quotient bits enter at bit 0.
    shifted  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    ge       = shifted >= {1'b0, b_mag};
    rem_next = ge ? shifted - {1'b0, b_mag} : shifted;
    prod     = neg_res ? -acc : acc;
    quot     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remd     = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= '0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op[2] == 1'b0) begin
              is_div   <= op[1];
              neg_res  <= sa ^ sb;
              neg_rem  <= sa;
              div_zero <= (b == '0);
              a_orig   <= a;
              b_mag    <= mag_b;
              acc      <= (2*WIDTH)'(mag_a);
              rem      <= '0;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= CALC;
            end else if (op[1] == 1'b0) begin
              if (op[0]) lo <= a;
              else       hi <= a;
              done <= 1'b1;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            rem              <= rem_next;
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            if (div_zero) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= quot;
              hi <= remd;
            end
          end else begin
            {hi, lo} <= prod;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table on a 32-bit instance, hand-written handshake
// corner cases, and the multiply cases repeated on an 8-bit instance.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start8 = 1'b0;
  logic [2:0]  op = '0, op8 = '0;
  logic [31:0] a = '0, b = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy, done, busy8, done8;
  logic [31:0] hi, lo;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op; returns edges from accept until done is seen and busy-high samples.
  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int bcnt);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 100) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dc;

    v[0] = '{"multu_max",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[1] = '{"mult_neg3x5", 3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    v[2] = '{"div_neg7_2",  3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{"div_7_neg2",  3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    v[4] = '{"divu_by0",    3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    v[5] = '{"div_by0_neg", 3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    v[6] = '{"div_ovf",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[7] = '{"mult_neg_neg",3'b000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
    v[8] = '{"divu_1000_7", 3'b011, 32'h000003E8, 32'h00000007, 32'h00000006, 32'h0000008E};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_hi8", 32'(hi8), 32'h0);

    foreach (v[i]) begin
      run32(v[i].op, v[i].a, v[i].b, lat, bcnt);
      chk({v[i].name, "_lat"}, 32'(lat), 32'd33);
      chk({v[i].name, "_busy"}, 32'(bcnt), 32'd33);
      chk({v[i].name, "_hi"}, hi, v[i].hi);
      chk({v[i].name, "_lo"}, lo, v[i].lo);
      @(negedge clk);
      chk({v[i].name, "_done_clr"}, 32'(done), 32'h0);
    end

    // start during CALC must be ignored; hi/lo keep the last table result until FIX
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 9) begin
        start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (i == 20) begin
        chk("hold_hi", hi, v[8].hi);
        chk("hold_lo", lo, v[8].lo);
      end
      if (done) dc++;
      @(negedge clk);
    end
    chk("ign_hi", hi, 32'h00000002);
    chk("ign_lo", lo, 32'h0000000E);
    chk("ign_done_cnt", 32'(dc), 32'd1);

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dc), 32'd0);
    run32(3'b001, 32'd3, 32'd4, lat, bcnt);
    chk("post_abort_lat", 32'(lat), 32'd33);
    chk("post_abort_lo", lo, 32'h0000000C);
    chk("post_abort_hi", hi, 32'h0);

    // mthi then mtlo back to back
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo_kept", lo, 32'h0000000C);
    chk("mthi_done", 32'(done), 32'h1);
    chk("mthi_busy", 32'(busy), 32'h0);
    op = 3'b101; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_done", 32'(done), 32'h1);
    chk("mtlo_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("mtx_done_clr", 32'(done), 32'h0);

    // no-op codes change nothing
    start = 1'b1; op = 3'b110; a = 32'hDEADBEEF; b = 32'h1;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    chk("nop_hi", hi, 32'h12345678);
    chk("nop_lo", lo, 32'h9ABCDEF0);
    chk("nop_done", 32'(done), 32'h0);
    chk("nop_busy", 32'(busy), 32'h0);

    // 8-bit instance
    run8(3'b001, 8'hFF, 8'hFF, lat, bcnt);
    chk("w8_multu_lat", 32'(lat), 32'd9);
    chk("w8_multu_busy", 32'(bcnt), 32'd9);
    chk("w8_multu_hi", 32'(hi8), 32'h000000FE);
    chk("w8_multu_lo", 32'(lo8), 32'h00000001);
    run8(3'b000, 8'hFD, 8'h05, lat, bcnt);
    chk("w8_mult_lat", 32'(lat), 32'd9);
    chk("w8_mult_hi", 32'(hi8), 32'h000000FF);
    chk("w8_mult_lo", 32'(lo8), 32'h000000F1);
    run8(3'b010, 8'hF9, 8'h02, lat, bcnt);
    chk("w8_div_hi", 32'(hi8), 32'h000000FF);
    chk("w8_div_lo", 32'(lo8), 32'h000000FD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
